// File: rtl/cpuc_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cpuc_mem_arbiter_pkg
//   Shared constants and types for the RAM-port arbiter: bus widths, number
//   of requesters, burst cap, arbiter state encoding, the per-requester beat
//   record and a helper for index widths.
// ----------------------------------------------------------------------------
package cpuc_mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;

    // Requesters: 0 = fetch, 1 = load/store, 2 = debug/DMA.
    localparam int NUM_REQ    = 3;
    // Longest locked burst; 1 turns locking off entirely.
    localparam int MAX_BURST  = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } t_arb_state;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  last;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } t_mem_req;

    // Width of an index into n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpuc_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cpuc_mem_arbiter_if
//   Requester-side bus of the arbiter.
//   req_valid/we/last/addr/wdata : one beat per requester (driven by master)
//   req_ready                    : one-hot acceptance (driven by slave)
//   rsp_valid/rsp_id/rsp_rdata   : registered read response (driven by slave)
//   Modports: master = requesters, slave = arbiter.
// ----------------------------------------------------------------------------
interface cpuc_mem_arbiter_if;
    import cpuc_mem_arbiter_pkg::*;

    localparam int ID_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               rsp_valid;
    logic [ID_W-1:0]                    rsp_id;
    logic [DATA_WIDTH-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_last, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_last, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );

endinterface

// File: rtl/cpuc_mem_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// cpuc_rr_pick
//   Combinational round-robin priority picker. Scans ptr+1, ptr+2, ...
//   (modulo N_REQ) and selects the first asserted valid bit.
//   valid  : request vector
//   ptr    : index of the most recent winner
//   grant  : one-hot winner (zero when nothing is valid)
//   winner : index of the winner (0 when nothing is valid)
//   any    : at least one request is valid
// ----------------------------------------------------------------------------
module cpuc_rr_pick
    import cpuc_mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int ID_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    int              idx;
    logic [ID_W-1:0] sel;

    always_comb begin
        // NOTE: every output and temporary gets a default before the scan,
        // so no path leaves one unassigned and no latch is inferred.
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            sel = ID_W'(idx);
            if (!any && valid[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                winner     = sel;
            end
        end
    end

endmodule

// File: rtl/cpuc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cpuc_mem_arbiter
//   Round-robin arbiter sharing one port of cpuc_dual_ram between NUM_REQ
//   requesters, with optional locked bursts capped at MAX_BURST beats.
//   clk, rst    : single clock, synchronous active-high reset
//   bus         : requester beats in, one-hot ready and read response out
//   ram_address : to RAM address_x (0 when idle)
//   ram_wren    : to RAM wren_x
//   ram_data    : to RAM data_x (0 when idle)
//   ram_q       : from RAM q_x, combinational read of ram_address
//   Read data returns exactly one cycle after acceptance; writes are silent.
// ----------------------------------------------------------------------------
module cpuc_mem_arbiter
    import cpuc_mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    cpuc_mem_arbiter_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int ID_W  = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    t_arb_state       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_winner;
    logic               pick_any;

    logic               accept;
    logic [ID_W-1:0]    acc_id;
    t_mem_req           sel;

    cpuc_rr_pick #(.N_REQ(NUM_REQ)) u_pick (
        .valid  (bus.req_valid),
        .ptr    (ptr_q),
        .grant  (pick_grant),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Next-state logic: who may be granted this cycle and how the lock evolves.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_W'(1);
        accept  = 1'b0;
        acc_id  = pick_winner;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    accept = 1'b1;
                    ptr_d  = pick_winner;
                    if (!bus.req_last[pick_winner] && MAX_BURST > 1) begin
                        state_d = ARB_OWN;
                        owner_d = pick_winner;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ARB_OWN: begin
                acc_id = owner_q;
                if (bus.req_valid[owner_q]) begin
                    accept = 1'b1;
                    cnt_d  = cnt_inc;
                    // Release on the marked last beat or when the cap is hit.
                    if (bus.req_last[owner_q] || cnt_inc == CNT_W'(MAX_BURST))
                        state_d = ARB_IDLE;
                end else begin
                    // Owner went quiet: give the port back to arbitration.
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Nothing is accepted while reset is held, so the RAM is not touched.
        if (rst)
            accept = 1'b0;
    end

    always_comb begin
        sel.valid = bus.req_valid[acc_id];
        sel.we    = bus.req_we[acc_id];
        sel.last  = bus.req_last[acc_id];
        sel.addr  = bus.req_addr[acc_id];
        sel.wdata = bus.req_wdata[acc_id];
    end

    always_comb begin
        bus.req_ready = '0;
        ram_wren      = 1'b0;
        ram_address   = '0;
        ram_data      = '0;
        if (accept) begin
            bus.req_ready[acc_id] = 1'b1;
            ram_wren              = sel.we;
            ram_address           = sel.addr;
            ram_data              = sel.wdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // values no matter in which order the statements are written.
        if (rst) begin
            state_q       <= ARB_IDLE;
            ptr_q         <= ID_W'(NUM_REQ - 1);
            owner_q       <= '0;
            cnt_q         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            bus.rsp_valid <= accept && !sel.we;
            if (accept && !sel.we) begin
                bus.rsp_id    <= acc_id;
                bus.rsp_rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_cpuc_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpuc_mem_arbiter
//   Randomised and directed stimulus against a behavioural arbiter/RAM model.
//   Expected read responses are queued at acceptance and checked by a
//   separate monitor when the DUT presents rsp_valid.
// ----------------------------------------------------------------------------
module tb_cpuc_mem_arbiter;
    import cpuc_mem_arbiter_pkg::*;

    localparam int ID_W  = idx_width(NUM_REQ);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpuc_mem_arbiter_if bus();

    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] ram_q;

    cpuc_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    // Stand-in for the RAM port: combinational read, write at the edge.
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    assign ram_q = ram[ram_address];
    always @(posedge clk) if (ram_wren) ram[ram_address] <= ram_data;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                    id;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    rsp_t                  exp_q[$];
    rsp_t                  mon_e;
    int                    m_ptr   = NUM_REQ - 1;
    int                    m_lock  = -1;   // requester holding the port, -1 = none
    int                    m_beats = 0;
    logic [DATA_WIDTH-1:0] m_mem [DEPTH];
    logic [NUM_REQ-1:0]    obs_ready;

    // Evaluate one cycle of the arbitration rules from the current inputs,
    // compare the DUT's combinational outputs and advance the model.
    task automatic model_step();
        int win;
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
        win = -1;
        obs_ready = bus.req_ready;
        if (rst) begin
            m_ptr = NUM_REQ - 1; m_lock = -1; m_beats = 0;
        end else if (m_lock >= 0) begin
            if (bus.req_valid[m_lock]) begin
                win = m_lock;
                m_beats++;
                if (bus.req_last[m_lock] || m_beats >= MAX_BURST) m_lock = -1;
            end else begin
                m_lock = -1;
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (win < 0 && bus.req_valid[i]) win = i;
            end
            if (win >= 0) begin
                m_ptr = win;
                if (!bus.req_last[win] && MAX_BURST > 1) begin
                    m_lock = win; m_beats = 1;
                end
            end
        end

        if (win >= 0) begin
            a = bus.req_addr[win];
            d = bus.req_wdata[win];
            check("ready", bus.req_ready, 32'(1) << win);
            check("ram_wren", ram_wren, bus.req_we[win]);
            check("ram_address", ram_address, a);
            check("ram_data", ram_data, d);
            if (bus.req_we[win]) m_mem[a] = d;
            else exp_q.push_back('{win, m_mem[a]});
        end else begin
            check("ready", bus.req_ready, 0);
            check("ram_wren", ram_wren, 0);
            check("ram_address", ram_address, 0);
            check("ram_data", ram_data, 0);
        end
    endtask

    // ---------------- response monitor ----------------
    always @(posedge clk) begin
        #1;
        if (bus.rsp_valid === 1'b1 || exp_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_valid", bus.rsp_valid, 1);
                check("rsp_id", bus.rsp_id, mon_e.id);
                check("rsp_rdata", bus.rsp_rdata, mon_e.data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input bit v, input bit we, input bit last,
                           input int addr, input int data);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_last[i]  = last;
        bus.req_addr[i]  = ADDR_WIDTH'(addr);
        bus.req_wdata[i] = DATA_WIDTH'(data);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0, 1, 0, 0);
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic step();
        #2;
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = DATA_WIDTH'(i * 7 + 3);
            m_mem[i] = DATA_WIDTH'(i * 7 + 3);
        end
        ram[5]   = 16'hA5A5;
        m_mem[5] = 16'hA5A5;
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;

        // Reset values of the response registers.
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);

        // 1: single read of preloaded word.
        set_req(0, 1, 0, 1, 5, 0);
        step();
        check("t1_ready", obs_ready, 3'b001);
        clear_reqs();
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_rsp_id", bus.rsp_id, 0);
        check("t1_rsp_rdata", bus.rsp_rdata, 16'hA5A5);
        step();

        // 2: three single-beat requesters rotate 0,1,2,0,1,2.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 0, 1, i + 8, 0);
        for (int j = 0; j < 6; j++) begin
            step();
            check("t2_order", obs_ready, 32'(1) << (j % NUM_REQ));
        end
        clear_reqs();
        step();

        // 3: 4-beat burst from req1 holds off req0 and req2.
        do_reset();
        set_req(0, 1, 0, 1, 1, 0);
        step();
        check("t3_pre", obs_ready, 3'b001);
        set_req(2, 1, 0, 1, 2, 0);
        for (int b = 1; b <= 4; b++) begin
            set_req(1, 1, 0, b == 4, 20 + b, 0);
            step();
            check("t3_burst", obs_ready, 3'b010);
        end
        set_req(1, 0, 0, 1, 0, 0);
        step();
        check("t3_after_a", obs_ready, 3'b100);
        step();
        check("t3_after_b", obs_ready, 3'b001);
        clear_reqs();
        step();

        // 4: unterminated stream from req2 is cut after MAX_BURST beats.
        do_reset();
        set_req(2, 1, 0, 0, 30, 0);
        step();
        check("t4_beat1", obs_ready, 3'b100);
        set_req(0, 1, 0, 1, 31, 0);
        for (int b = 2; b <= MAX_BURST; b++) begin
            step();
            check("t4_beat", obs_ready, 3'b100);
        end
        step();
        check("t4_release", obs_ready, 3'b001);
        clear_reqs();
        step();

        // 5: write then read-back on the next cycle.
        set_req(1, 1, 1, 1, 7, 16'h1234);
        step();
        check("t5_wr_ready", obs_ready, 3'b010);
        check("t5_wr_no_rsp", bus.rsp_valid, 0);
        set_req(1, 1, 0, 1, 7, 0);
        step();
        clear_reqs();
        check("t5_rd_valid", bus.rsp_valid, 1);
        check("t5_rd_id", bus.rsp_id, 1);
        check("t5_rd_data", bus.rsp_rdata, 16'h1234);
        step();

        // 6: reset on beat 2 of a burst.
        do_reset();
        set_req(1, 1, 1, 0, 40, 16'hBEEF);
        step();
        check("t6_beat1", obs_ready, 3'b010);
        set_req(1, 1, 0, 0, 41, 0);
        set_req(0, 1, 0, 1, 42, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_ready", obs_ready, 3'b000);
        check("t6_rsp_valid", bus.rsp_valid, 0);
        set_req(1, 1, 0, 1, 41, 0);
        step();
        check("t6_req0_wins", obs_ready, 3'b001);
        clear_reqs();
        step();

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom);
            step();
        end
        rst = 1'b0;
        clear_reqs();
        step();
        step();
        check("drain_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
